// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI-attached RAM controller.
// Command encodings match the two low bits of the spi_slave receive word.
package spi_pkg;

  localparam int RX_W = 10;
  localparam int TX_W = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef enum logic {
    IDLE     = 1'b0,
    RD_ARMED = 1'b1
  } rd_state_e;

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Command/response bundle between spi_slave (master side) and the RAM controller.
interface spi_ram_ctrl_if;
  import spi_pkg::*;

  logic [RX_W-1:0] rx_data;
  logic            rx_valid;
  logic [TX_W-1:0] tx_data;
  logic            tx_valid;
  logic            cmd_err;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, tx_valid, cmd_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, tx_valid, cmd_err
  );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-port synchronous byte array with a registered read port.
// Read data only moves on a read enable, so it doubles as the held tx byte.
module spi_ram_mem #(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [ADDR_width-1:0] addr_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o
);

  logic [7:0] mem_q [MEM_DEPTH];
  logic [7:0] rdata_q;

  // The array itself is deliberately never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// Executes WR_ADDR / WR_DATA / RD_ADDR / RD_DATA words from spi_slave against
// a single-port byte RAM; one command per rising edge of rx_valid.
module spi_ram_ctrl
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH  = 256,
  parameter int ADDR_width = 8
) (
  input logic           clk,
  input logic           rst,
  spi_ram_ctrl_if.slave bus
);

  rd_state_e             state_q, state_d;
  logic                  rx_valid_q;
  logic [ADDR_width-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_width-1:0] rd_addr_q, rd_addr_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  cmd_err_q, cmd_err_d;

  logic                  mem_we;
  logic                  mem_re;
  logic [ADDR_width-1:0] mem_addr;
  logic [TX_W-1:0]       mem_rdata;

  logic [TX_W-1:0]       payload;
  cmd_e                  cmd;
  logic                  accept;

  assign payload = bus.rx_data[RX_W-1:2];
  assign cmd     = cmd_e'(bus.rx_data[1:0]);
  // Gating with rst means a command coinciding with reset is simply dropped.
  assign accept  = bus.rx_valid & ~rx_valid_q & ~rst;

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    tx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = wr_addr_q;

    if (accept) begin
      case (cmd)
        WR_ADDR: wr_addr_d = payload[ADDR_width-1:0];
        WR_DATA: mem_we = 1'b1;
        RD_ADDR: begin
          rd_addr_d = payload[ADDR_width-1:0];
          state_d   = RD_ARMED;
        end
        RD_DATA: begin
          if (state_q == RD_ARMED) begin
            mem_re     = 1'b1;
            mem_addr   = rd_addr_q;
            tx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rx_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_valid_q <= bus.rx_valid;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_width(ADDR_width)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .we_i   (mem_we),
    .re_i   (mem_re),
    .addr_i (mem_addr),
    .wdata_i(payload),
    .rdata_o(mem_rdata)
  );

  assign bus.tx_data  = mem_rdata;
  assign bus.tx_valid = tx_valid_q;
  assign bus.cmd_err  = cmd_err_q;

endmodule
